// File: rtl/mem_mpu_guard_if.sv
// ============================================================================
// Module      : mem_mpu_guard_if
// Description : CPU-side native memory bus plus SRAM-side bus seen by the MPU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_mpu_guard_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  is_inst;
    logic [31:0]           pc_addr;
    logic                  inform_cpu_wait;
    logic                  interrupt;

    logic                  cpu_valid;
    logic                  cpu_ready;
    logic [21:0]           cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [3:0]            cpu_wstrb;
    logic [DATA_WIDTH-1:0] cpu_rdata;

    logic [3:0]            mem_wen;
    logic [21:0]           mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // The guard itself
    modport slave (
        input  is_inst, pc_addr, cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb, mem_rdata,
        output inform_cpu_wait, interrupt, cpu_ready, cpu_rdata, mem_wen, mem_addr, mem_wdata
    );

    // The CPU + SRAM environment around the guard
    modport master (
        output is_inst, pc_addr, cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb, mem_rdata,
        input  inform_cpu_wait, interrupt, cpu_ready, cpu_rdata, mem_wen, mem_addr, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_mpu_guard.sv
// ============================================================================
// Module      : mem_mpu_guard
// Description : Memory protection unit between picorv32 and SRAM; loads a
//               region table from SRAM after reset, then filters accesses.
//               Define MPU_IRQ_EN to drive the violation interrupt pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_mpu_guard #(
    parameter int DATA_WIDTH     = 32,
    parameter int MPU_START_ADDR = 768,
    parameter int MPU_LEN        = 16
) (
    input wire             clk,
    input wire             resetn,
    mem_mpu_guard_if.slave bus
);

    localparam logic [1:0]            c_st_load  = 2'd0;
    localparam logic [1:0]            c_st_idle  = 2'd1;
    localparam logic [1:0]            c_st_done  = 2'd2;
    localparam logic [21:0]           c_tbl_base = 22'(MPU_START_ADDR);
    localparam logic [21:0]           c_tbl_end  = 22'(MPU_START_ADDR + MPU_LEN);
    localparam logic [4:0]            c_load_end = 5'(MPU_LEN);
    localparam logic [DATA_WIDTH-1:0] c_nop      = DATA_WIDTH'(32'h0000_0013);
    // A 16-word table holds word 0 plus seven base/limit pairs at most
    localparam int                    c_nregions = 7;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [4:0]            r_load_cnt;
    logic [DATA_WIDTH-1:0] r_shadow [0:15];

    logic                  r_allowed;
    logic                  r_write;
    logic                  r_inst;
    logic [21:0]           r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [3:0]            r_wstrb;

    logic                  w_en;
    logic [2:0]            w_nreg;
    logic                  w_is_write;
    logic [21:0]           w_pc_word;
    logic                  w_pc_in_r0;
    logic [c_nregions-1:0] w_grant;
    logic                  w_allowed;
    logic                  w_irq;
    logic                  w_tbl_hit;
    logic [3:0]            w_tbl_idx;
    logic                  w_unused;

    // ------------------------------------------------------------------
    // Permission check against the shadow table
    // ------------------------------------------------------------------
    assign w_en       = r_shadow[0][0];
    assign w_nreg     = r_shadow[0][3:1];
    assign w_is_write = |bus.cpu_wstrb;
    assign w_pc_word  = bus.pc_addr[23:2];
    assign w_pc_in_r0 = (w_nreg != 3'd0)
                     && (w_pc_word >= r_shadow[1][21:0])
                     && (w_pc_word <  r_shadow[2][21:0]);

    generate
        for (genvar g = 0; g < c_nregions; g++) begin : g_region
            logic [21:0] w_base;
            logic [21:0] w_limit;
            logic [3:0]  w_rwxt;
            logic        w_hit;
            logic        w_perm;

            assign w_base  = r_shadow[1 + 2*g][21:0];
            assign w_rwxt  = r_shadow[1 + 2*g][31:28];
            assign w_limit = r_shadow[2 + 2*g][21:0];
            assign w_hit   = (3'(g) < w_nreg)
                          && (bus.cpu_addr >= w_base)
                          && (bus.cpu_addr <  w_limit);
            // Bits of w_rwxt: 3=R, 2=W, 1=X, 0=T
            assign w_perm  = w_is_write  ? w_rwxt[2] :
                             bus.is_inst ? w_rwxt[1] : w_rwxt[3];
            assign w_grant[g] = w_hit && w_perm && (!w_rwxt[0] || w_pc_in_r0);
        end
    endgenerate

    assign w_allowed = !w_en || (|w_grant);

    assign w_tbl_hit = (r_addr >= c_tbl_base) && (r_addr < c_tbl_end);
    assign w_tbl_idx = 4'(r_addr - c_tbl_base);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (resetn) begin
            r_state <= c_st_load;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_load: if (r_load_cnt == c_load_end) w_next_state = c_st_idle;
            c_st_idle: if (bus.cpu_valid)            w_next_state = c_st_done;
            c_st_done:                               w_next_state = c_st_idle;
            default:                                 w_next_state = c_st_load;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.inform_cpu_wait = 1'b0;
        bus.cpu_ready       = 1'b0;
        bus.cpu_rdata       = '0;
        bus.mem_wen         = 4'h0;
        bus.mem_addr        = bus.cpu_addr;
        bus.mem_wdata       = bus.cpu_wdata;
        w_irq               = 1'b0;
        // Reset gates everything so an in-flight write never reaches SRAM
        if (resetn) begin
            bus.inform_cpu_wait = 1'b1;
        end else begin
            case (r_state)
                c_st_load: begin
                    bus.inform_cpu_wait = 1'b1;
                    bus.mem_addr        = c_tbl_base + 22'(r_load_cnt);
                end
                c_st_idle: begin
                    if (bus.cpu_valid && w_allowed) bus.mem_wen = bus.cpu_wstrb;
                end
                c_st_done: begin
                    bus.cpu_ready = 1'b1;
                    w_irq         = !r_allowed;
                    if (r_write)        bus.cpu_rdata = '0;
                    else if (r_allowed) bus.cpu_rdata = bus.mem_rdata;
                    else if (r_inst)    bus.cpu_rdata = c_nop;
                    else                bus.cpu_rdata = '0;
                end
                default: ;
            endcase
        end
    end

`ifdef MPU_IRQ_EN
    assign bus.interrupt = w_irq;
    assign w_unused      = ^{bus.pc_addr[31:24], bus.pc_addr[1:0]};
`else
    assign bus.interrupt = 1'b0;
    assign w_unused      = ^{bus.pc_addr[31:24], bus.pc_addr[1:0], w_irq};
`endif

    // ------------------------------------------------------------------
    // Table load, request capture and shadow write-through
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (resetn) begin
            r_load_cnt <= 5'd0;
            for (int i = 0; i < 16; i++) r_shadow[i] <= '0;
            r_allowed  <= 1'b0;
            r_write    <= 1'b0;
            r_inst     <= 1'b0;
            r_addr     <= 22'd0;
            r_wdata    <= '0;
            r_wstrb    <= 4'h0;
        end else begin
            case (r_state)
                c_st_load: begin
                    // SRAM data trails the address by one cycle
                    if (r_load_cnt != 5'd0) r_shadow[4'(r_load_cnt - 5'd1)] <= bus.mem_rdata;
                    if (r_load_cnt != c_load_end) r_load_cnt <= r_load_cnt + 5'd1;
                end
                c_st_idle: begin
                    if (bus.cpu_valid) begin
                        r_allowed <= w_allowed;
                        r_write   <= w_is_write;
                        r_inst    <= bus.is_inst;
                        r_addr    <= bus.cpu_addr;
                        r_wdata   <= bus.cpu_wdata;
                        r_wstrb   <= bus.cpu_wstrb;
                    end
                end
                c_st_done: begin
                    if (r_allowed && r_write && w_tbl_hit) begin
                        for (int b = 0; b < 4; b++) begin
                            if (r_wstrb[b]) r_shadow[w_tbl_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_mpu_guard.sv
// ============================================================================
// Module      : tb_mem_mpu_guard
// Description : Directed self-checking bench for mem_mpu_guard with an SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_mpu_guard;

    logic clk = 1'b0;
    logic resetn;
    int   vectors = 0;
    int   miscompares = 0;

`ifdef MPU_IRQ_EN
    localparam logic c_irq_on = 1'b1;
`else
    localparam logic c_irq_on = 1'b0;
`endif

    mem_mpu_guard_if #(.DATA_WIDTH(32)) bus ();

    mem_mpu_guard #(
        .DATA_WIDTH     (32),
        .MPU_START_ADDR (768),
        .MPU_LEN        (16)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    // SRAM model: registered read, byte-write, plus a bench-side loading port
    logic [31:0] sram [0:1023];
    logic        bd_we = 1'b0;
    logic [9:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;

    always @(posedge clk) begin
        bus.mem_rdata <= sram[bus.mem_addr[9:0]];
        for (int b = 0; b < 4; b++) begin
            if (bus.mem_wen[b]) sram[bus.mem_addr[9:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
        if (bd_we) sram[bd_addr] <= bd_data;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bd_write(input logic [9:0] a, input logic [31:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        @(negedge clk);
        bd_we   = 1'b0;
    endtask

    // Called right after resetn is dropped at a negedge
    task automatic wait_load(input string tag);
        int n = 0;
        while (bus.inform_cpu_wait === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check(tag, n, 17);
    endtask

    // Called at a negedge in IDLE; returns at the negedge after DONE
    task automatic access(input string tag, input logic inst, input logic [31:0] pc,
                          input logic [21:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                          output logic [3:0] wen, output logic [31:0] rd, output logic irq);
        bus.is_inst   = inst;
        bus.pc_addr   = pc;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        bus.cpu_wstrb = ws;
        bus.cpu_valid = 1'b1;
        #1;
        wen = bus.mem_wen;
        check({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'(addr));
        @(negedge clk);
        check({tag, ".ready"}, 32'(bus.cpu_ready), 32'd1);
        rd  = bus.cpu_rdata;
        irq = bus.interrupt;
        bus.cpu_valid = 1'b0;
        bus.cpu_wstrb = 4'h0;
        @(negedge clk);
        check({tag, ".ready_1cyc"}, 32'(bus.cpu_ready), 32'd0);
    endtask

    logic [31:0] tbl1 [0:15];
    logic [31:0] tbl2 [0:15];
    logic [3:0]  wen;
    logic [31:0] rd;
    logic        irq;

    initial begin
        for (int i = 0; i < 16; i++) begin
            tbl1[i] = 32'h0;
            tbl2[i] = 32'h0;
        end
        tbl1[0] = 32'h0000_0005;             // EN, 2 regions
        tbl1[1] = 32'hE000_0000;             // RWX base 0
        tbl1[2] = 32'h0000_0100;
        tbl1[3] = 32'hA000_0200;             // RX base 0x200
        tbl1[4] = 32'h0000_0300;
        tbl2[0] = 32'h0000_0007;             // EN, 3 regions
        tbl2[1] = 32'hE000_0000;
        tbl2[2] = 32'h0000_0100;
        tbl2[3] = 32'hB000_0200;             // RX + T
        tbl2[4] = 32'h0000_0300;
        tbl2[5] = 32'hC000_0300;             // RW over the table itself
        tbl2[6] = 32'h0000_0310;

        resetn        = 1'b1;
        bus.is_inst   = 1'b0;
        bus.pc_addr   = 32'h0;
        bus.cpu_valid = 1'b0;
        bus.cpu_addr  = 22'h0;
        bus.cpu_wdata = 32'h0;
        bus.cpu_wstrb = 4'h0;

        @(negedge clk);
        for (int i = 0; i < 16; i++) bd_write(10'(768 + i), tbl1[i]);
        bd_write(10'h010, 32'h0000_0093);
        bd_write(10'h210, 32'h1111_2222);
        bd_write(10'h250, 32'h0000_55AA);
        bd_write(10'h020, 32'h0BAD_0020);
        bd_write(10'h150, 32'h1234_5678);

        check("rst.cpu_ready", 32'(bus.cpu_ready), 32'd0);
        check("rst.interrupt", 32'(bus.interrupt), 32'd0);
        check("rst.mem_wen", 32'(bus.mem_wen), 32'd0);
        check("rst.cpu_rdata", bus.cpu_rdata, 32'd0);
        check("rst.wait", 32'(bus.inform_cpu_wait), 32'd1);

        resetn = 1'b0;
        wait_load("load1.wait_cycles");
        check("load1.shadow0", dut.r_shadow[0], 32'h0000_0005);
        check("load1.shadow1", dut.r_shadow[1], 32'hE000_0000);
        check("load1.shadow2", dut.r_shadow[2], 32'h0000_0100);
        check("load1.shadow3", dut.r_shadow[3], 32'hA000_0200);
        check("load1.shadow4", dut.r_shadow[4], 32'h0000_0300);

        access("fetch_ok", 1'b1, 32'h40, 22'h010, 32'h0, 4'h0, wen, rd, irq);
        check("fetch_ok.wen", 32'(wen), 32'd0);
        check("fetch_ok.rdata", rd, 32'h0000_0093);
        check("fetch_ok.irq", 32'(irq), 32'd0);

        access("wr_ro", 1'b0, 32'h40, 22'h210, 32'hDEAD_BEEF, 4'hF, wen, rd, irq);
        check("wr_ro.wen", 32'(wen), 32'd0);
        check("wr_ro.rdata", rd, 32'd0);
        check("wr_ro.irq", 32'(irq), 32'(c_irq_on));
        check("wr_ro.sram", sram[10'h210], 32'h1111_2222);

        access("fetch_nohit", 1'b1, 32'h40, 22'h150, 32'h0, 4'h0, wen, rd, irq);
        check("fetch_nohit.rdata", rd, 32'h0000_0013);
        check("fetch_nohit.irq", 32'(irq), 32'(c_irq_on));

        access("rd_nohit", 1'b0, 32'h40, 22'h150, 32'h0, 4'h0, wen, rd, irq);
        check("rd_nohit.rdata", rd, 32'd0);
        check("rd_nohit.irq", 32'(irq), 32'(c_irq_on));

        access("rd_ok", 1'b0, 32'h40, 22'h250, 32'h0, 4'h0, wen, rd, irq);
        check("rd_ok.rdata", rd, 32'h0000_55AA);
        check("rd_ok.irq", 32'(irq), 32'd0);

        // Word 0x300 equals region 1's exclusive limit, so no region covers it
        access("wr_limit", 1'b0, 32'h40, 22'h300, 32'h0, 4'h1, wen, rd, irq);
        check("wr_limit.wen", 32'(wen), 32'd0);
        check("wr_limit.irq", 32'(irq), 32'(c_irq_on));
        check("wr_limit.shadow0", dut.r_shadow[0], 32'h0000_0005);

        // Reset during a permitted write must suppress it
        bus.is_inst   = 1'b0;
        bus.cpu_addr  = 22'h020;
        bus.cpu_wdata = 32'hCAFE_F00D;
        bus.cpu_wstrb = 4'hF;
        bus.cpu_valid = 1'b1;
        resetn        = 1'b1;
        #1;
        check("rst_mid.wen", 32'(bus.mem_wen), 32'd0);
        @(negedge clk);
        bus.cpu_valid = 1'b0;
        bus.cpu_wstrb = 4'h0;
        check("rst_mid.ready", 32'(bus.cpu_ready), 32'd0);
        for (int i = 0; i < 16; i++) bd_write(10'(768 + i), tbl2[i]);
        check("rst_mid.sram", sram[10'h020], 32'h0BAD_0020);

        resetn = 1'b0;
        wait_load("load2.wait_cycles");
        check("load2.shadow0", dut.r_shadow[0], 32'h0000_0007);
        check("load2.shadow3", dut.r_shadow[3], 32'hB000_0200);

        access("t_out", 1'b0, 32'h1000, 22'h250, 32'h0, 4'h0, wen, rd, irq);
        check("t_out.rdata", rd, 32'd0);
        check("t_out.irq", 32'(irq), 32'(c_irq_on));

        access("t_in", 1'b0, 32'h40, 22'h250, 32'h0, 4'h0, wen, rd, irq);
        check("t_in.rdata", rd, 32'h0000_55AA);
        check("t_in.irq", 32'(irq), 32'd0);

        // Clear byte 0 of word 768: EN=0, NREG=0
        access("tbl_wr", 1'b0, 32'h40, 22'h300, 32'hFFFF_FF00, 4'h1, wen, rd, irq);
        check("tbl_wr.wen", 32'(wen), 32'h1);
        check("tbl_wr.irq", 32'(irq), 32'd0);
        check("tbl_wr.shadow0", dut.r_shadow[0], 32'h0000_0000);
        check("tbl_wr.sram", sram[10'h300], 32'h0000_0000);

        access("wr_open", 1'b0, 32'h1000, 22'h210, 32'hDEAD_BEEF, 4'hF, wen, rd, irq);
        check("wr_open.wen", 32'(wen), 32'hF);
        check("wr_open.irq", 32'(irq), 32'd0);
        check("wr_open.rdata", rd, 32'd0);
        check("wr_open.sram", sram[10'h210], 32'hDEAD_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_mpu_guard.md
Name: mem_mpu_guard

Overview:
- Memory protection unit between the picorv32 native memory interface and the single-port SRAM.
- After reset it copies a region table from SRAM into shadow registers, stalling the CPU while it does so.
- It then checks every CPU access against that table; permitted accesses are forwarded, denied ones are blocked and reported.

Parameters:
- DATA_WIDTH, 32: data width; only 32 is supported.
- MPU_START_ADDR, 768: SRAM word address of the config table.
- MPU_LEN, 16: config table length in words; must be 16.

Ports:
- clk  in  1: clock.
- resetn  in  1: synchronous, active-high reset (1 = reset asserted).
- is_inst  in  1: 1 = instruction fetch.
- pc_addr  in  32: byte PC of the current instruction.
- inform_cpu_wait  out  1: CPU must hold off.
- interrupt  out  1: violation pulse to the CPU IRQ.
- cpu_valid  in  1: request valid.
- cpu_ready  out  1: request done.
- cpu_addr  in  22: word address.
- cpu_wdata  in  32: write data.
- cpu_wstrb  in  4: byte strobes; 0 = read.
- cpu_rdata  out  32: read data.
- mem_wen  out  4: SRAM byte write enables.
- mem_addr  out  22: SRAM word address.
- mem_wdata  out  32: SRAM write data.
- mem_rdata  in  32: SRAM read data; valid one cycle after the address.

Behaviour:
- Reset values: cpu_ready=0, interrupt=0, mem_wen=0, cpu_rdata=0, inform_cpu_wait=1, shadow table=0, state=LOAD, load counter=0.
- Reset asserted mid-operation aborts any access and restarts LOAD.
- States: LOAD, IDLE, DONE.
- LOAD:
  - Drives mem_addr=MPU_START_ADDR+k for k=0..MPU_LEN-1, one per cycle, with mem_wen=0.
  - Captures mem_rdata one cycle later into shadow word k.
  - After the last capture (MPU_LEN+1 cycles), deasserts inform_cpu_wait and goes to IDLE.
  - cpu_valid is ignored during LOAD.
- Table word 0: bit0 EN, bits[3:1] NREG (0..7 regions).
- Region r (r < NREG) uses two words:
  - word 1+2r: bits[21:0] BASE, bit31 R, bit30 W, bit29 X, bit28 T.
  - word 2+2r: bits[21:0] LIMIT, exclusive.
- A region hits when BASE <= cpu_addr < LIMIT (unsigned).
- Required permission:
  - is_inst=1 needs X.
  - is_inst=0 with wstrb=0 needs R.
  - wstrb!=0 needs W.
- If T=1, the region additionally requires pc_addr[23:2] to lie inside region 0.
- Access is allowed if any hitting region grants it.
- EN=0 allows everything. EN=1 with no hit denies.
- IDLE with cpu_valid=1, cycle T:
  - mem_addr=cpu_addr and mem_wdata=cpu_wdata (combinational).
  - mem_wen=cpu_wstrb if allowed, else 0.
  - Go to DONE.
- DONE, cycle T+1:
  - cpu_ready=1 for exactly one cycle.
  - cpu_rdata=mem_rdata if allowed read/fetch; 0x00000013 (NOP) for a denied fetch; 0 for a denied read or any write.
  - interrupt=1 for this one cycle if denied.
  - Return to IDLE.
  - A new request is accepted no earlier than T+2.
- Permitted writes to words MPU_START_ADDR..MPU_START_ADDR+MPU_LEN-1 also update the shadow copy byte-wise in the DONE cycle. The new table applies from the next request.
- Outside LOAD, mem_addr follows cpu_addr and mem_wen=0 whenever no access is being issued.

Optional Feature:
- Macro MPU_IRQ_EN.
- Defined: interrupt pulses on a violation as described above.
- Undefined: interrupt is tied to 0. Violations are still blocked and return the NOP/0 data.

Test Plan:
- Reset then release, table {0x5, R|W|X 0..0x100, R|X 0x200..0x300} → inform_cpu_wait high for 17 cycles after reset release; shadow words match.
- Fetch at word 0x10 with SRAM value 0x00000093 → mem_wen=0, cpu_ready one cycle later, cpu_rdata=0x00000093, interrupt=0.
- Write 0xDEADBEEF with wstrb=0xF to word 0x210 (R|X region only) → mem_wen stays 0, SRAM unchanged, cpu_ready with interrupt=1 one cycle.
- Fetch at word 0x150 (no region) → cpu_rdata=0x00000013, interrupt=1.
- Set EN=0 via a permitted write to word 768 → next write to 0x210 lands in SRAM, interrupt=0.
- T-bit region accessed with pc_addr outside region 0 → denied; same access with pc_addr inside region 0 → allowed.
